rfblackwidow_fetch_queue: RTL
=============================

// Module: rfblackwidow_fetch_queue
// PURPOSE
// - Parametrised N-lane instruction fetch/bundle stage with a decoupling bundle queue.
// - Sits between the BIU instruction-cache port and the decode stage.
// - Slices ic_line into NLANES instructions and truncates each bundle after the first branch.
// - Buffers up to QDEPTH bundles so icache misses and decode stalls overlap; flushes on redirect.
// PARAMETERS
// - NLANES    3        instructions per bundle (1..8)
// - INSN_W    40       instruction width, bits; multiple of 8
// - IP_W      80       instruction pointer width
// - LINE_W    1024     icache line width; must satisfy LINE_W/8 >= 64 + NLANES*INSN_W/8
// - QDEPTH    4        bundle queue entries; power of 2, >= 2
// - BR_BIT    6        bit index of the branch flag within an instruction
// - RESET_IP  80'h00FFFFFFFFFFFFFD0000   fetch address after reset
// PORTS
// - clk_i            in   1                  clock
// - rst_i            in   1                  asynchronous reset, active-high
// - ic_ip_o          out  IP_W               fetch address presented to icache
// - ihit_i           in   1                  ic_line_i is valid for ic_ip_o
// - ic_line_i        in   LINE_W             icache line
// - redirect_i       in   1                  branch/exception redirect
// - redirect_ip_i    in   IP_W               new fetch address
// - bundle_valid_o   out  1                  queue head valid
// - bundle_ready_i   in   1                  decode accepts head
// - bundle_o         out  NLANES*INSN_W      head instructions; lane 0 in LSBs
// - bundle_ip_o      out  IP_W               address of lane 0
// - bundle_lane_v_o  out  NLANES             per-lane valid; contiguous from lane 0
// - q_count_o        out  $clog2(QDEPTH)+1   occupied entries
// BEHAVIOUR
// - Reset, asynchronous: fip=RESET_IP, count=0, rd/wr pointers=0, storage=0.
//   Resulting outputs: ic_ip_o=RESET_IP; bundle_valid_o=0; bundle_o, bundle_ip_o, bundle_lane_v_o, q_count_o all 0.
// - ic_ip_o = fip (registered).
// - Window: win = ic_line_i >> {fip[5:0],3'b0}. lane k = win[k*INSN_W +: INSN_W].
// - Lane valid: lane 0 is always valid. Lane k>0 is valid iff no lane j<k has bit BR_BIT set.
//   A branch lane itself is included in the bundle.
// - Fetch step: nv = popcount(lane_v). Next fip = fip + nv*(INSN_W/8), width IP_W, modulo wrap.
// - push = ihit_i & !redirect_i & (count<QDEPTH | pop).
//   On push: write {win lanes, fip, lane_v} at wr_ptr, then advance fip.
// - pop = bundle_valid_o & bundle_ready_i. On pop, rd_ptr advances.
// - bundle_valid_o = (count!=0). Head outputs are read from the entry at rd_ptr.
// - Latency: ihit_i at cycle t gives bundle_valid_o at t+1 when the queue was empty.
// - Full (count==QDEPTH): no push unless pop in the same cycle; fip holds.
// - Empty: pop impossible; bundle_valid_o=0, and bundle_ready_i is ignored.
// - Push and pop in the same cycle: count is unchanged and both pointers advance.
// - Pointers wrap modulo QDEPTH.
// - Redirect has priority over everything: count<=0, rd_ptr<=wr_ptr, fip<=redirect_ip_i.
//   No push that cycle; a pop that cycle is void.
//   bundle_valid_o=0 next cycle; the first new bundle can appear 2 cycles after redirect_i.
// - ihit_i low: no push, fip holds, pops continue.
// CONFIGURATION
// - Macro RFBW_FETCH_STATS_EN, when defined, adds two outputs:
//   - stall_cnt_o, 32 bits: increments when bundle_ready_i & !bundle_valid_o.
//   - bundle_cnt_o, 32 bits: increments on each pop.
//   - Both reset to 0, wrap at 2^32, and are cleared by nothing except rst_i. Redirect does not clear them.
// - Macro undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - rfBlackWidowPkg gains:
//   - FetchBundle struct: insn array, ip, lane_v.
//   - INSN_BYTES = INSN_W/8.
//   - FETCH_OFS_W = 6.
// - Sub-module rfblackwidow_fetch_fifo: generic synchronous FIFO of FetchBundle with flush input.
//   It holds pointers, count and storage. The top level holds fip, the lane slicer and the branch-truncate logic.
// TESTING
// - Reset: rst_i=1 mid-run -> ic_ip_o=RESET_IP, bundle_valid_o=0, q_count_o=0 immediately, asynchronously.
// - Straight-line code: NLANES=3, no branch bits, ihit_i=1 -> lane_v=3'b111.
//   Successive bundle_ip_o step by 15; count saturates at 4 when bundle_ready_i=0.
// - Branch in lane 0 -> lane_v=3'b001, fip+=5. Branch in lane 1 only -> lane_v=3'b011, fip+=10.
// - Full plus pop: count=4, ihit_i=1, ready=1 -> push and pop both occur, count stays 4, no entry is lost.
// - Redirect with count=3 and push pending: redirect_ip_i=80'h1000 -> count=0 next cycle.
//   ic_ip_o=80'h1000. The next bundle_ip_o is 80'h1000.
// - Stats on: 10 cycles of ready with an empty queue, then 5 pops -> stall_cnt_o=10, bundle_cnt_o=5.

Source files
------------

// File: rtl/rfblackwidow_fetch_queue_pkg.sv
// Shared types and sizing for the rfBlackWidow fetch/bundle stage.
// Optional statistics counters are enabled by defining RFBW_FETCH_STATS_EN.
package rfblackwidow_fetch_queue_pkg;

    localparam int unsigned NLANES      = 3;
    localparam int unsigned INSN_W      = 40;
    localparam int unsigned IP_W        = 80;
    localparam int unsigned LINE_W      = 1024;
    localparam int unsigned QDEPTH      = 4;
    localparam int unsigned BR_BIT      = 6;
    localparam int unsigned INSN_BYTES  = INSN_W / 8;
    localparam int unsigned FETCH_OFS_W = 6;
    localparam int unsigned LANES_W     = NLANES * INSN_W;
    localparam int unsigned QCNT_W      = $clog2(QDEPTH) + 1;

    localparam logic [IP_W-1:0] RESET_IP = 80'h00FF_FFFF_FFFF_FFFD_0000;

    typedef struct packed {
        logic [NLANES-1:0]             lane_v;
        logic [IP_W-1:0]               ip;
        logic [NLANES-1:0][INSN_W-1:0] insn;
    } fetch_bundle_t;

    // Number of valid lanes in a bundle.
    function automatic int unsigned lane_count(input logic [NLANES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(NLANES); i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rfblackwidow_fetch_queue_if.sv
// Icache-side and decode-side signals of the fetch queue.
// Statistics outputs exist only when RFBW_FETCH_STATS_EN is defined.
interface rfblackwidow_fetch_queue_if;
    import rfblackwidow_fetch_queue_pkg::*;

    logic [IP_W-1:0]          ic_ip_o;
    logic                     ihit_i;
    logic [LINE_W-1:0]        ic_line_i;
    logic                     redirect_i;
    logic [IP_W-1:0]          redirect_ip_i;
    logic                     bundle_valid_o;
    logic                     bundle_ready_i;
    logic [LANES_W-1:0]       bundle_o;
    logic [IP_W-1:0]          bundle_ip_o;
    logic [NLANES-1:0]        bundle_lane_v_o;
    logic [QCNT_W-1:0]        q_count_o;
`ifdef RFBW_FETCH_STATS_EN
    logic [31:0]              stall_cnt_o;
    logic [31:0]              bundle_cnt_o;

    modport master (
        output ic_ip_o, bundle_valid_o, bundle_o, bundle_ip_o, bundle_lane_v_o, q_count_o,
               stall_cnt_o, bundle_cnt_o,
        input  ihit_i, ic_line_i, redirect_i, redirect_ip_i, bundle_ready_i
    );
    modport slave (
        input  ic_ip_o, bundle_valid_o, bundle_o, bundle_ip_o, bundle_lane_v_o, q_count_o,
               stall_cnt_o, bundle_cnt_o,
        output ihit_i, ic_line_i, redirect_i, redirect_ip_i, bundle_ready_i
    );
`else
    modport master (
        output ic_ip_o, bundle_valid_o, bundle_o, bundle_ip_o, bundle_lane_v_o, q_count_o,
        input  ihit_i, ic_line_i, redirect_i, redirect_ip_i, bundle_ready_i
    );
    modport slave (
        input  ic_ip_o, bundle_valid_o, bundle_o, bundle_ip_o, bundle_lane_v_o, q_count_o,
        output ihit_i, ic_line_i, redirect_i, redirect_ip_i, bundle_ready_i
    );
`endif

endinterface

// File: rtl/rfblackwidow_fetch_fifo.sv
// Synchronous FIFO of fetch bundles with a flush that discards every entry.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module rfblackwidow_fetch_fifo
    import rfblackwidow_fetch_queue_pkg::*;
#(
    parameter type         T     = fetch_bundle_t,
    parameter int unsigned DEPTH = QDEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  T                         wdata_i,
    output T                         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                   mem_q [DEPTH];
    T                   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // Flush parks the read pointer on the write pointer; storage is left stale.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop_i) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            count_d = CNT_W'(count_q + CNT_W'(push_i) - CNT_W'(pop_i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rfblackwidow_fetch_queue.sv
// N-lane instruction fetch stage: slices the icache line, truncates after the first branch,
// and queues bundles for decode. Define RFBW_FETCH_STATS_EN to add stall/bundle counters.
module rfblackwidow_fetch_queue
    import rfblackwidow_fetch_queue_pkg::*;
#(
    parameter int unsigned     BR_IDX = BR_BIT,
    parameter logic [IP_W-1:0] RST_IP = RESET_IP
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    rfblackwidow_fetch_queue_if.master  bus
);

    logic [IP_W-1:0]     fip_q, fip_d;
    logic [LANES_W-1:0]  win_c;
    logic [IP_W-1:0]     step_c;
    fetch_bundle_t       wr_c;
    fetch_bundle_t       head_c;
    logic [QCNT_W-1:0]   count_c;
    logic                valid_c;
    logic                push_c;
    logic                pop_c;

    // Lane slicing and branch truncation; a branch lane is kept, lanes after it are dropped.
    always_comb begin
        wr_c  = '0;
        win_c = LANES_W'(bus.ic_line_i >> {fip_q[FETCH_OFS_W-1:0], 3'b000});
        for (int k = 0; k < int'(NLANES); k++) begin
            wr_c.insn[k] = win_c[k*INSN_W +: INSN_W];
        end
        wr_c.lane_v[0] = 1'b1;
        for (int k = 1; k < int'(NLANES); k++) begin
            wr_c.lane_v[k] = wr_c.lane_v[k-1] & ~wr_c.insn[k-1][BR_IDX];
        end
        wr_c.ip = fip_q;
        step_c  = IP_W'(lane_count(wr_c.lane_v) * INSN_BYTES);
    end

    // Redirect voids any pop and blocks the push of that cycle.
    always_comb begin
        valid_c = (count_c != '0);
        pop_c   = valid_c & bus.bundle_ready_i & ~bus.redirect_i;
        push_c  = bus.ihit_i & ~bus.redirect_i & ((count_c < QCNT_W'(QDEPTH)) | pop_c);
        fip_d   = fip_q;
        if (bus.redirect_i) begin
            fip_d = bus.redirect_ip_i;
        end else if (push_c) begin
            fip_d = fip_q + step_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fip_q <= RST_IP;
        end else begin
            fip_q <= fip_d;
        end
    end

    rfblackwidow_fetch_fifo #(
        .T     (fetch_bundle_t),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.redirect_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (wr_c),
        .rdata_o (head_c),
        .count_o (count_c)
    );

    assign bus.ic_ip_o         = fip_q;
    assign bus.bundle_valid_o  = valid_c;
    assign bus.bundle_o        = head_c.insn;
    assign bus.bundle_ip_o     = head_c.ip;
    assign bus.bundle_lane_v_o = head_c.lane_v;
    assign bus.q_count_o       = count_c;

`ifdef RFBW_FETCH_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bundle_cnt_q, bundle_cnt_d;

    // Free-running counters; only reset clears them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q + 32'(bus.bundle_ready_i & ~valid_c);
        bundle_cnt_d = bundle_cnt_q + 32'(pop_c);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            bundle_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bundle_cnt_q <= bundle_cnt_d;
        end
    end

    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.bundle_cnt_o = bundle_cnt_q;
`endif

endmodule
